keypoint_drain_arbiter: RTL and testbench

Drains the two keypoint SRAMs filled by the detect/filter stage (layer 1 and layer 2, 19-bit {row[8:0], col[9:0]} entries) into a single valid/ready stream for the orientation/descriptor stage. Arbitrates round-robin between the two SRAM read ports. Tags each entry with its layer. Absorbs downstream backpressure with a small output FIFO. Starts after the detect pass reports done; owns both SRAM read ports while busy.

---
 rtl/keypoint_drain_arbiter.sv | 132 +++++++++++++
 tb/tb_keypoint_drain_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/keypoint_drain_arbiter.sv
// Drains the layer-1 and layer-2 keypoint SRAMs round-robin into one tagged valid/ready stream.
// A small FIFO absorbs backpressure. Reads are only issued when the FIFO has room for them.
module keypoint_drain_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [11:0]       kp1_count,
  input  logic [11:0]       kp2_count,
  output logic              kp1_re,
  output logic [ADDR_W-1:0] kp1_addr,
  input  logic [DATA_W-1:0] kp1_dout,
  output logic              kp2_re,
  output logic [ADDR_W-1:0] kp2_addr,
  input  logic [DATA_W-1:0] kp2_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_data,
  output logic              busy,
  output logic              done
);

  localparam int          PTR_W   = $clog2(FIFO_DEPTH);
  localparam int          OCC_W   = PTR_W + 2;
  localparam logic [11:0] MAX_CNT = 12'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state_reg;
  logic [11:0]       rem1_reg, rem2_reg;
  logic [ADDR_W-1:0] ptr1_reg, ptr2_reg;
  logic              last_grant_reg;     // 0 = layer 1 granted last
  logic              inflight_reg;
  logic              inflight_layer_reg;

  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    fifo_count_reg;

  logic              can_issue, grant1, grant2, push, pop;
  logic [11:0]       rem1_next, rem2_next;
  logic [OCC_W-1:0]  occupancy;

  function automatic logic [11:0] clamp_count(input logic [11:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  // Occupancy counts the read in flight so a returning word always has a slot.
  assign occupancy = OCC_W'(fifo_count_reg) + OCC_W'(inflight_reg);
  assign can_issue = (state_reg == RUN) && (occupancy < OCC_W'(FIFO_DEPTH));
  assign grant1    = can_issue && (rem1_reg != 12'd0) && ((rem2_reg == 12'd0) || last_grant_reg);
  assign grant2    = can_issue && (rem2_reg != 12'd0) && ((rem1_reg == 12'd0) || !last_grant_reg);
  assign rem1_next = rem1_reg - 12'(grant1);
  assign rem2_next = rem2_reg - 12'(grant2);

  assign kp1_re    = grant1;
  assign kp2_re    = grant2;
  assign kp1_addr  = ptr1_reg;
  assign kp2_addr  = ptr2_reg;

  assign push      = inflight_reg;
  assign out_valid = (fifo_count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_mem[rd_ptr_reg] : '0;

  assign busy      = (state_reg == RUN) || (state_reg == FLUSH);
  assign done      = (state_reg == DONE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {inflight_layer_reg, inflight_layer_reg ? kp2_dout : kp1_dout};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      rem1_reg           <= '0;
      rem2_reg           <= '0;
      ptr1_reg           <= '0;
      ptr2_reg           <= '0;
      last_grant_reg     <= 1'b1;
      inflight_reg       <= 1'b0;
      inflight_layer_reg <= 1'b0;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      fifo_count_reg     <= '0;
    end else begin
      inflight_reg       <= grant1 || grant2;
      inflight_layer_reg <= grant2;
      if (grant1) begin
        ptr1_reg       <= ptr1_reg + 1'b1;
        last_grant_reg <= 1'b0;
      end
      if (grant2) begin
        ptr2_reg       <= ptr2_reg + 1'b1;
        last_grant_reg <= 1'b1;
      end
      rem1_reg <= rem1_next;
      rem2_reg <= rem2_next;

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      fifo_count_reg <= fifo_count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

      case (state_reg)
        IDLE: begin
          if (start) begin
            rem1_reg       <= clamp_count(kp1_count);
            rem2_reg       <= clamp_count(kp2_count);
            ptr1_reg       <= '0;
            ptr2_reg       <= '0;
            last_grant_reg <= 1'b1;
            if ((kp1_count == 12'd0) && (kp2_count == 12'd0)) state_reg <= DONE;
            else                                              state_reg <= RUN;
          end
        end
        RUN: begin
          if ((rem1_next == 12'd0) && (rem2_next == 12'd0)) state_reg <= FLUSH;
        end
        FLUSH: begin
          if (!inflight_reg && (fifo_count_reg == '0)) state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypoint_drain_arbiter.sv
// Bench for keypoint_drain_arbiter: table of drains plus random drains, checked against an
// expected-order list built from the arbitration rules and a per-cycle monitor.
module tb_keypoint_drain_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] kp1_count = '0, kp2_count = '0;
  logic        kp1_re, kp2_re;
  logic [10:0] kp1_addr, kp2_addr;
  logic [18:0] kp1_dout = '0, kp2_dout = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [19:0] out_data;
  logic        busy, done;

  int tests = 0, fails = 0, cyc = 0, start_cyc = 0;

  typedef struct {int c1; int c2; int mode; int exp_done; int exp_first;} vec_t;
  vec_t vecs[10];

  int          exp_layer[$], exp_addr[$];
  logic [19:0] exp_word[$];
  int          iss_idx, acc_idx, first_valid_rel, done_rel, done_cnt;
  bit          mon_active = 0, prev_stall = 0;
  logic [19:0] prev_data;

  keypoint_drain_arbiter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kp1_count(kp1_count), .kp2_count(kp2_count),
    .kp1_re(kp1_re), .kp1_addr(kp1_addr), .kp1_dout(kp1_dout),
    .kp2_re(kp2_re), .kp2_addr(kp2_addr), .kp2_dout(kp2_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [18:0] sram_word(input int layer, input int a);
    return layer ? (19'(a * 91 + 1000) ^ 19'h40000) : 19'(a * 37 + 5);
  endfunction

  // Registered-read SRAM contents are a fixed function of the address.
  always @(posedge clk) begin
    if (kp1_re) kp1_dout <= sram_word(0, int'(kp1_addr));
    if (kp2_re) kp2_dout <= sram_word(1, int'(kp2_addr));
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_active) begin
      int rel;
      rel = cyc - start_cyc + 1;
      chk(!(kp1_re && kp2_re), "dual_re", 1, 0);
      chk(!(kp1_re || kp2_re) || busy, "re_outside_run", int'(kp1_re | kp2_re), 0);
      if (kp1_re || kp2_re) begin
        int layer, addr;
        layer = kp2_re ? 1 : 0;
        addr  = kp2_re ? int'(kp2_addr) : int'(kp1_addr);
        if (iss_idx >= exp_layer.size()) begin
          chk(0, "extra_read", iss_idx, exp_layer.size());
        end else begin
          chk(layer == exp_layer[iss_idx], "read_layer", layer, exp_layer[iss_idx]);
          chk(addr == exp_addr[iss_idx], "read_addr", addr, exp_addr[iss_idx]);
        end
        chk(iss_idx - acc_idx < 4, "fifo_room", iss_idx - acc_idx, 3);
        iss_idx++;
      end
      if (prev_stall) chk(out_valid && out_data == prev_data, "hold_stable", out_data, prev_data);
      if (out_valid && first_valid_rel < 0) first_valid_rel = rel;
      if (out_valid && out_ready) begin
        if (acc_idx >= exp_word.size()) chk(0, "extra_output", acc_idx, exp_word.size());
        else chk(out_data == exp_word[acc_idx], "out_data", out_data, exp_word[acc_idx]);
        acc_idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        done_cnt++;
        done_rel = rel;
        chk(!busy, "busy_with_done", busy, 0);
        chk(acc_idx == exp_word.size(), "done_after_all", acc_idx, exp_word.size());
      end
    end
  end

  // Expected issue order: alternate while both layers remain, layer 1 first.
  task automatic build_model(input int c1, input int c2);
    int r[2], a[2], last, g;
    r[0] = (c1 > 2048) ? 2048 : c1;
    r[1] = (c2 > 2048) ? 2048 : c2;
    a[0] = 0; a[1] = 0; last = 1;
    exp_layer.delete(); exp_addr.delete(); exp_word.delete();
    while (r[0] + r[1] > 0) begin
      if (r[0] > 0 && r[1] > 0) g = 1 - last;
      else g = (r[0] > 0) ? 0 : 1;
      exp_layer.push_back(g);
      exp_addr.push_back(a[g]);
      exp_word.push_back({1'(g), sram_word(g, a[g])});
      a[g]++; r[g]--; last = g;
    end
  endtask

  task automatic run_drain(input vec_t v);
    build_model(v.c1, v.c2);
    iss_idx = 0; acc_idx = 0; first_valid_rel = -1; done_rel = -1; done_cnt = 0;
    prev_stall = 0;
    @(negedge clk);
    kp1_count = 12'(v.c1); kp2_count = 12'(v.c2); start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_cyc = cyc; mon_active = 1;
    for (int k = 0; k < 20000 && done_cnt == 0; k++) begin
      case (v.mode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc - start_cyc + 1) % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
    end
    chk(done_cnt == 1, "done_seen", done_cnt, 1);
    repeat (4) @(posedge clk);
    #1;
    chk(done_cnt == 1, "done_once", done_cnt, 1);
    mon_active = 0;
    chk(iss_idx == exp_layer.size(), "reads_issued", iss_idx, exp_layer.size());
    chk(acc_idx == exp_word.size(), "entries_out", acc_idx, exp_word.size());
    if (v.exp_done >= 0) chk(done_rel == v.exp_done, "done_latency", done_rel, v.exp_done);
    if (v.exp_first >= 0) chk(first_valid_rel == v.exp_first, "first_valid", first_valid_rel, v.exp_first);
    if (exp_word.size() == 0) chk(first_valid_rel == -1, "never_valid", first_valid_rel, -1);
    $display("[TB] drain c1=%0d c2=%0d mode=%0d: %0d entries, done at +%0d", v.c1, v.c2, v.mode,
             acc_idx, done_rel);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({kp1_re, kp2_re, kp1_addr, kp2_addr, out_valid, out_data, busy, done} == '0, tag,
        {kp1_re, kp2_re, out_valid, busy, done}, 0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{3, 2, 0, 9, 3};
    vecs[1] = '{0, 0, 0, 1, -1};
    vecs[2] = '{0, 4, 0, 8, 3};
    vecs[3] = '{5, 5, 1, -1, 3};
    vecs[4] = '{2048, 3000, 0, 4100, 3};
    vecs[5] = '{1, 0, 0, 5, 3};
    for (int i = 6; i < 10; i++) begin
      vecs[i] = '{int'($urandom_range(0, 30)), int'($urandom_range(0, 30)), 2, -1, -1};
    end

    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset_outputs");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("idle_outputs");

    for (int i = 0; i < 10; i++) run_drain(vecs[i]);

    // Second start mid-drain is ignored; reset then abandons the drain silently.
    @(negedge clk);
    kp1_count = 12'd5; kp2_count = 12'd5; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; kp1_count = 12'd0; kp2_count = 12'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk(busy == 1'b1, "busy_after_restart", busy, 1);
    chk(kp1_re == 1'b1 && kp1_addr == 11'd2, "restart_ignored_addr", kp1_addr, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs("midrun_reset_outputs");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk(done == 1'b0 && busy == 1'b0, "no_done_after_reset", done, 0);
    end
    $display("[TB] mid-drain reset sequence complete");
    v = '{3, 2, 0, 9, 3};
    run_drain(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
